// File: rtl/lms_adapt_engine.sv
// lms_adapt_engine: LMS coefficient-update engine for an N_COEF-tap adaptive FFE.
// A TRAIN phase with a large step size runs for TRAIN_LEN updates, then TRACK continues
// with a smaller step size. Supports freeze, leakage, saturation of the accumulators and
// clamping of the sliced output coefficients.
module lms_adapt_engine #(
    parameter int DATA_BW    = 9,
    parameter int DATA_FBITS = 7,
    parameter int ERR_BW     = 8,
    parameter int MU_BW      = 8,
    parameter int COEF_BW    = 9,
    parameter int COEF_FBITS = 7,
    parameter int ACC_BW     = 25,
    parameter int ACC_FBITS  = 21,
    parameter int N_COEF     = 7,
    parameter int CENTER_TAP = 3,
    parameter int TRAIN_LEN  = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic signed [DATA_BW-1:0]   i_data,
    input  logic signed [ERR_BW-1:0]    i_error,
    input  logic signed [MU_BW-1:0]     i_mu_train,
    input  logic signed [MU_BW-1:0]     i_mu_track,
    input  logic                        i_start,
    input  logic                        i_freeze,
    input  logic [3:0]                  i_leak_shift,
    input  logic                        i_sat_clr,
    output logic [COEF_BW*N_COEF-1:0]   o_coefs,
    output logic [1:0]                  o_state,
    output logic                        o_sat
);

    localparam int EW_BW   = ERR_BW + MU_BW;
    localparam int CORR_BW = EW_BW + DATA_BW;
    localparam int WIDE_BW = ACC_BW + ERR_BW + MU_BW + DATA_BW;
    localparam int SHIFT   = ACC_FBITS - COEF_FBITS;
    localparam int CNT_BW  = $clog2(TRAIN_LEN) + 1;

    localparam logic signed [ACC_BW-1:0]  C_ONE    = ACC_BW'(1) << ACC_FBITS;
    localparam logic signed [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic signed [WIDE_BW-1:0] WIDE_MAX = {{(WIDE_BW-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
    localparam logic signed [WIDE_BW-1:0] WIDE_MIN = {{(WIDE_BW-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};
    localparam logic signed [ACC_BW-1:0]  OUT_MAX  = {{(ACC_BW-COEF_BW+1){1'b0}}, {(COEF_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0]  OUT_MIN  = {{(ACC_BW-COEF_BW+1){1'b1}}, {(COEF_BW-1){1'b0}}};
    localparam logic [CNT_BW-1:0]         CNT_LAST = CNT_BW'(TRAIN_LEN - 1);

    // Error and step size both carry 7 fractional bits; the product with x must land on the accumulator LSB.
    generate
        if (7 + 7 + DATA_FBITS != ACC_FBITS) begin : g_fbits_check
            $error("lms_adapt_engine: 14 + DATA_FBITS must equal ACC_FBITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_update;
    logic [CNT_BW-1:0]           r_cnt;
    logic signed [DATA_BW-1:0]   r_x [1:N_COEF-1];
    logic signed [DATA_BW-1:0]   w_x [N_COEF];
    logic signed [ACC_BW-1:0]    r_c [N_COEF];
    logic signed [ACC_BW-1:0]    w_c_next [N_COEF];
    logic signed [MU_BW-1:0]     w_mu;
    logic signed [EW_BW-1:0]     w_ew;
    logic signed [CORR_BW-1:0]   w_corr [N_COEF];
    logic signed [WIDE_BW-1:0]   w_sum [N_COEF];
    logic signed [WIDE_BW-1:0]   w_c_wide [N_COEF];
    logic signed [ACC_BW-1:0]    w_slice [N_COEF];
    logic                        w_sat_any;
    logic                        r_sat;

    // Delay line: tap 0 is the live sample, older samples shift in on every strobe regardless of state.
    always_comb begin
        w_x[0] = i_data;
        for (int k = 1; k < N_COEF; k++) begin
            w_x[k] = r_x[k];
        end
    end

    // Delay-line registers.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            for (int k = 1; k < N_COEF; k++) r_x[k] <= '0;
        end else if (i_en) begin
            r_x[1] <= i_data;
            for (int k = 2; k < N_COEF; k++) r_x[k] <= r_x[k-1];
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic and update qualification; start overrides any update in the same cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_update     = (r_state != S_IDLE) && i_en && !i_freeze && !i_start;
        if (i_start) begin
            w_state_next = S_TRAIN;
        end else if (r_state == S_TRAIN && w_update && r_cnt == CNT_LAST) begin
            w_state_next = S_TRACK;
        end
    end

    // Training update counter: cleared on start, advanced only by TRAIN updates, held by freeze.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_start)                    r_cnt <= '0;
        else if (w_update && r_state == S_TRAIN) r_cnt <= r_cnt + 1'b1;
    end

    // LMS datapath: c + e*mu*x - leak, evaluated wide, then saturated back into the accumulator range.
    always_comb begin
        w_sat_any = 1'b0;
        w_mu      = (r_state == S_TRAIN) ? i_mu_train : i_mu_track;
        w_ew      = $signed({{MU_BW{i_error[ERR_BW-1]}}, i_error}) *
                    $signed({{ERR_BW{w_mu[MU_BW-1]}}, w_mu});
        for (int k = 0; k < N_COEF; k++) begin
            w_corr[k]   = $signed({{DATA_BW{w_ew[EW_BW-1]}}, w_ew}) *
                          $signed({{EW_BW{w_x[k][DATA_BW-1]}}, w_x[k]});
            w_c_wide[k] = {{(WIDE_BW-ACC_BW){r_c[k][ACC_BW-1]}}, r_c[k]};
            w_sum[k]    = w_c_wide[k] + {{(WIDE_BW-CORR_BW){w_corr[k][CORR_BW-1]}}, w_corr[k]};
            if (i_leak_shift != 4'd0) begin
                w_sum[k] = w_sum[k] - (w_c_wide[k] >>> i_leak_shift);
            end
            if (w_sum[k] > WIDE_MAX) begin
                w_c_next[k] = ACC_MAX;
                w_sat_any   = 1'b1;
            end else if (w_sum[k] < WIDE_MIN) begin
                w_c_next[k] = ACC_MIN;
                w_sat_any   = 1'b1;
            end else begin
                w_c_next[k] = w_sum[k][ACC_BW-1:0];
            end
        end
    end

    // Coefficient accumulators: reload to a unit centre tap on reset or start, otherwise update when qualified.
    always_ff @(posedge i_clk) begin
        // NOTE: the accumulator array is reset explicitly because the FIR must start from a known impulse.
        if (i_rst || i_start) begin
            for (int k = 0; k < N_COEF; k++) r_c[k] <= (k == CENTER_TAP) ? C_ONE : '0;
        end else if (w_update) begin
            for (int k = 0; k < N_COEF; k++) r_c[k] <= w_c_next[k];
        end
    end

    // Sticky saturation flag; a saturating update in the same cycle wins over the clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)                      r_sat <= 1'b0;
        else if (w_update && w_sat_any) r_sat <= 1'b1;
        else if (i_sat_clr)             r_sat <= 1'b0;
    end

    // Output slicing: truncate accumulator fraction down to COEF_FBITS and clamp to the coefficient range.
    always_comb begin
        o_coefs = '0;
        for (int k = 0; k < N_COEF; k++) begin
            w_slice[k] = r_c[k] >>> SHIFT;
            if (w_slice[k] > OUT_MAX)      o_coefs[k*COEF_BW +: COEF_BW] = OUT_MAX[COEF_BW-1:0];
            else if (w_slice[k] < OUT_MIN) o_coefs[k*COEF_BW +: COEF_BW] = OUT_MIN[COEF_BW-1:0];
            else                           o_coefs[k*COEF_BW +: COEF_BW] = w_slice[k][COEF_BW-1:0];
        end
    end

    assign o_state = r_state;
    assign o_sat   = r_sat;

endmodule
